// File: rtl/jk_ctrl_pkg.sv
// Shared definitions for the JK bank scheduler: operation codes,
// controller states and the op -> {J,K} mapping.
package jk_ctrl_pkg;

   typedef enum logic [1:0] {
      JK_HOLD   = 2'b00,
      JK_SET    = 2'b01,
      JK_CLR    = 2'b10,
      JK_TOGGLE = 2'b11
   } jk_op_e;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      APPLY  = 2'b01,
      SETTLE = 2'b10
   } sched_state_e;

   // Returns {J,K} for the targeted bit of an operation.
   function automatic logic [1:0] jk_bits(input jk_op_e op);
      case (op)
         JK_SET:    jk_bits = 2'b10;
         JK_CLR:    jk_bits = 2'b01;
         JK_TOGGLE: jk_bits = 2'b11;
         default:   jk_bits = 2'b00;
      endcase
   endfunction

endpackage

// File: rtl/jk_bank.sv
// Bank of WIDTH JK flip-flops with an asynchronous active-high clear.
module jk_bank #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] j,
   input  logic [WIDTH-1:0] k,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;

   // Characteristic equation per bit: Q+ = J&~Q | ~K&Q (hold/set/clear/invert).
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign q_d[gi] = (j[gi] & ~q_q[gi]) | (~k[gi] & q_q[gi]);
   end

   // Bank state register, cleared immediately by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/jk_bank_sched.sv
// Round-robin scheduler sharing one JK flip-flop bank between NREQ requesters.
// One command is granted from IDLE, driven onto J/K for one APPLY cycle, then
// the bank is left alone for SETTLE_CYC cycles before the next grant.
module jk_bank_sched
   import jk_ctrl_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int NREQ       = 4,
   parameter int IDXW       = 3,
   parameter int SETTLE_CYC = 2
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic [NREQ-1:0]      Req,
   input  logic [2*NREQ-1:0]    Op,
   input  logic [NREQ*IDXW-1:0] Idx,
   output logic [NREQ-1:0]      Gnt,
   output logic [WIDTH-1:0]     J,
   output logic [WIDTH-1:0]     K,
   output logic [WIDTH-1:0]     Q,
   output logic                 Busy,
   output logic                 Err
);

   localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CNTW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

   sched_state_e     state_q, state_d;
   logic [PTRW-1:0]  ptr_q, ptr_d;
   logic [CNTW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0] j_q, j_d;
   logic [WIDTH-1:0] k_q, k_d;
   logic             busy_q, busy_d;
   logic             err_q, err_d;

   logic             win_found;
   int               win_int;
   logic             grant_ok;
   logic [1:0]       sel_op;
   logic [IDXW-1:0]  sel_idx;
   logic             sel_oob;
   logic [WIDTH-1:0] sel_mask;
   logic [1:0]       sel_jk;

   // Round-robin search: first Req set, starting at ptr and wrapping.
   always_comb begin
      int cand;
      cand      = 0;
      win_found = 1'b0;
      win_int   = 0;
      for (int n = 0; n < NREQ; n++) begin
         cand = int'(ptr_q) + n;
         if (cand >= NREQ) begin
            cand = cand - NREQ;
         end
         if (!win_found && Req[cand]) begin
            win_found = 1'b1;
            win_int   = cand;
         end
      end
   end

   // Grants are only offered from IDLE and never while reset is asserted.
   assign grant_ok = (state_q == IDLE) && win_found && !Rst;
   assign Gnt      = grant_ok ? (NREQ'(1) << win_int) : '0;

   // Winner's command decoded into a bit mask and J/K polarity.
   always_comb begin
      sel_op   = Op[2*win_int +: 2];
      sel_idx  = Idx[IDXW*win_int +: IDXW];
      sel_oob  = int'(sel_idx) >= WIDTH;
      sel_mask = sel_oob ? '0 : (WIDTH'(1) << sel_idx);
      sel_jk   = jk_bits(jk_op_e'(sel_op));
   end

   // Next-state logic. The J/K/Err registers are the command latch: they are
   // loaded at the grant edge, so they are valid for exactly the APPLY cycle.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      j_d     = '0;
      k_d     = '0;
      err_d   = 1'b0;
      busy_d  = busy_q;
      unique case (state_q)
         IDLE: begin
            if (grant_ok) begin
               state_d = APPLY;
               ptr_d   = (win_int == NREQ - 1) ? '0 : PTRW'(win_int + 1);
               busy_d  = 1'b1;
               j_d     = sel_jk[1] ? sel_mask : '0;
               k_d     = sel_jk[0] ? sel_mask : '0;
               err_d   = sel_oob;
            end
         end
         APPLY: begin
            if (SETTLE_CYC > 0) begin
               state_d = SETTLE;
               cnt_d   = '0;
            end else begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         end
         SETTLE: begin
            if (int'(cnt_q) >= SETTLE_CYC - 1) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNTW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // Controller registers; reset drops any in-flight command.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
         j_q     <= '0;
         k_q     <= '0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         j_q     <= j_d;
         k_q     <= k_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
      end
   end

   jk_bank #(
      .WIDTH (WIDTH)
   ) u_bank (
      .clk (Clk),
      .rst (Rst),
      .j   (j_q),
      .k   (k_q),
      .q   (Q)
   );

   assign J    = j_q;
   assign K    = k_q;
   assign Busy = busy_q;
   assign Err  = err_q;

endmodule
